// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: round-robin ALU/LSU writeback arbitration plus a busy scoreboard.
// Optional macro WB_BYPASS_EN lets a same-cycle writeback clear its busy bit for the stall check.
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   issue_rs1,
    input  logic [AW-1:0]   issue_rs2,
    output logic            issue_stall,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    output logic            wb_en,
    output logic [AW-1:0]   wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic [NREG-1:0] busy_vec
);

    typedef enum logic {SRC_ALU = 1'b0, SRC_LSU = 1'b1} src_e;

    src_e            last_grant_q, last_grant_d;
    logic            wb_en_q, wb_en_d;
    logic [AW-1:0]   wb_addr_q, wb_addr_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic [NREG-1:0] busy_eff;

    logic            grant_alu, grant_lsu, xfer, issue_fire;
    logic [AW-1:0]   xfer_rd;
    logic [XLEN-1:0] xfer_data;

    // Nothing is granted while reset is held, so no requester believes it transferred.
    assign grant_alu = !reset && alu_valid && (!lsu_valid || last_grant_q == SRC_LSU);
    assign grant_lsu = !reset && lsu_valid && (!alu_valid || last_grant_q == SRC_ALU);
    assign xfer      = grant_alu || grant_lsu;
    assign xfer_rd   = grant_alu ? alu_rd   : lsu_rd;
    assign xfer_data = grant_alu ? alu_data : lsu_data;

    assign alu_ready = grant_alu;
    assign lsu_ready = grant_lsu;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        busy_eff = busy_q;
`ifdef WB_BYPASS_EN
        if (xfer) busy_eff[xfer_rd] = 1'b0;
`endif
    end

    assign issue_stall = issue_valid &&
                         (busy_eff[issue_rs1] || busy_eff[issue_rs2] || busy_eff[issue_rd]);
    assign issue_fire  = issue_valid && !issue_stall;

    // Clear is applied before set, so a same-cycle set of the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (xfer && xfer_rd != '0)          busy_d[xfer_rd]  = 1'b0;
        if (issue_fire && issue_rd != '0)   busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_alu)      last_grant_d = SRC_ALU;
        else if (grant_lsu) last_grant_d = SRC_LSU;
    end

    // x0 transfers are accepted but never raise the write enable.
    assign wb_en_d   = xfer && (xfer_rd != '0);
    assign wb_addr_d = xfer ? xfer_rd   : wb_addr_q;
    assign wb_data_d = xfer ? xfer_data : wb_data_q;

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= SRC_LSU;
            wb_en_q      <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            busy_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wb_en_q      <= wb_en_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
            busy_q       <= busy_d;
        end
    end

    assign wb_en    = wb_en_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a behavioural model checked every cycle,
// plus literal expectations on the key scenarios.
module tb_regfile_wb_arbiter;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd, issue_rs1, issue_rs2;
    logic            issue_stall;
    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            lsu_valid;
    logic [AW-1:0]   lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            lsu_ready;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic [NREG-1:0] busy_vec;

    int n_cmp  = 0;
    int n_fail = 0;

    regfile_wb_arbiter #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
        .issue_rs2(issue_rs2), .issue_stall(issue_stall),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Grant codes: 0 none, 1 ALU, 2 LSU.
    bit [31:0] m_busy;
    int        m_last;
    bit        m_wb_en;
    bit [4:0]  m_wb_addr;
    bit [31:0] m_wb_data;
    bit        model_valid = 1'b0;

    function automatic int m_grant();
        if (reset) return 0;
        if (alu_valid && lsu_valid) return (m_last == 2) ? 1 : 2;
        if (alu_valid) return 1;
        if (lsu_valid) return 2;
        return 0;
    endfunction

    function automatic bit [4:0] m_rd();
        return (m_grant() == 1) ? alu_rd : lsu_rd;
    endfunction

    function automatic bit [31:0] m_data();
        return (m_grant() == 1) ? alu_data : lsu_data;
    endfunction

    function automatic bit m_stall();
        bit [31:0] b;
        b = m_busy;
`ifdef WB_BYPASS_EN
        if (m_grant() != 0) b[m_rd()] = 1'b0;
`endif
        return issue_valid && (b[issue_rs1] || b[issue_rs2] || b[issue_rd]);
    endfunction

    function automatic bit [31:0] m_next_busy();
        bit [31:0] b;
        b = m_busy;
        if (m_grant() != 0 && m_rd() != 0) b[m_rd()] = 1'b0;
        if (issue_valid && !m_stall() && issue_rd != 0) b[issue_rd] = 1'b1;
        return b;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_busy      <= '0;
            m_last      <= 2;
            m_wb_en     <= 1'b0;
            m_wb_addr   <= '0;
            m_wb_data   <= '0;
            model_valid <= 1'b1;
        end else begin
            m_busy  <= m_next_busy();
            m_wb_en <= (m_grant() != 0) && (m_rd() != 0);
            if (m_grant() != 0) begin
                m_last    <= m_grant();
                m_wb_addr <= m_rd();
                m_wb_data <= m_data();
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_valid && !reset) begin
            check("cmp_alu_ready",   alu_ready,   m_grant() == 1);
            check("cmp_lsu_ready",   lsu_ready,   m_grant() == 2);
            check("cmp_issue_stall", issue_stall, m_stall());
            check("cmp_wb_en",       wb_en,       m_wb_en);
            check("cmp_wb_addr",     wb_addr,     m_wb_addr);
            check("cmp_wb_data",     wb_data,     m_wb_data);
            check("cmp_busy_vec",    busy_vec,    m_busy);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    endtask

    initial begin
        logic [4:0] a_rd [3];
        logic [4:0] l_rd [2];
        bit         exp_alu [5];
        logic [4:0] exp_addr [5];
        int ai, li;
        a_rd = '{5'd1, 5'd3, 5'd8};
        l_rd = '{5'd2, 5'd4};
        exp_alu  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_addr = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd8};

        reset = 1; idle();
        cyc(); cyc();
        reset = 0;
        #1;
        check("rst_wb_en", wb_en, 0);
        check("rst_busy", busy_vec, 0);
        check("rst_stall", issue_stall, 0);
        check("rst_alu_ready", alu_ready, 0);
        check("rst_lsu_ready", lsu_ready, 0);

        // RAW on x5 resolved by an ALU writeback.
        issue_valid = 1; issue_rd = 5; issue_rs1 = 0; issue_rs2 = 0;
        #1 check("issue5_nostall", issue_stall, 0);
        cyc();
        check("busy5_set", busy_vec, 32'h20);
        issue_rd = 6; issue_rs1 = 5;
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        #1;
        check("raw_alu_ready", alu_ready, 1);
`ifdef WB_BYPASS_EN
        check("raw_stall_bypass", issue_stall, 0);
`else
        check("raw_stall", issue_stall, 1);
`endif
        cyc();
        alu_valid = 0;
        check("raw_wb_en", wb_en, 1);
        check("raw_wb_addr", wb_addr, 5);
        check("raw_wb_data", wb_data, 32'hDEADBEEF);
        check("busy5_clear", busy_vec[5], 0);
`ifndef WB_BYPASS_EN
        #1 check("raw_stall_drop", issue_stall, 0);
`endif
        cyc();
        issue_valid = 0;
        #1 check("busy6_set", busy_vec, 32'h40);

        // LSU retires x6, leaving last grant on LSU.
        lsu_valid = 1; lsu_rd = 6; lsu_data = 32'h66;
        #1 check("lsu6_ready", lsu_ready, 1);
        cyc();
        lsu_valid = 0;
        check("busy6_clear", busy_vec, 0);
        check("lsu6_addr", wb_addr, 6);

        // Contention: alternating grants, requesters hold until ready.
        ai = 0; li = 0;
        for (int i = 0; i < 5; i++) begin
            alu_valid = (ai < 3);
            if (ai < 3) begin alu_rd = a_rd[ai]; alu_data = 32'hA000_0000 + 32'(a_rd[ai]); end
            lsu_valid = (li < 2);
            if (li < 2) begin lsu_rd = l_rd[li]; lsu_data = 32'hB000_0000 + 32'(l_rd[li]); end
            #1;
            check("rr_alu_ready", alu_ready, exp_alu[i]);
            check("rr_lsu_ready", lsu_ready, !exp_alu[i]);
            if (alu_ready) ai++;
            if (lsu_ready) li++;
            cyc();
            check("rr_wb_en", wb_en, 1);
            check("rr_wb_addr", wb_addr, exp_addr[i]);
        end
        alu_valid = 0; lsu_valid = 0;

        // x0 writeback and WAW stall.
        issue_valid = 1; issue_rd = 7; issue_rs1 = 0; issue_rs2 = 0;
        cyc();
        issue_valid = 0;
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h12345678;
        #1 check("x0_lsu_ready", lsu_ready, 1);
        cyc();
        lsu_valid = 0;
        check("x0_wb_en", wb_en, 0);
        check("x0_busy", busy_vec, 32'h80);
        issue_valid = 1; issue_rd = 7;
        #1 check("waw_stall", issue_stall, 1);
        issue_valid = 0;
        alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
        cyc();
        alu_valid = 0;
        check("busy7_clear", busy_vec, 0);
        issue_valid = 1; issue_rd = 3; issue_rs1 = 0; issue_rs2 = 0;
        #1 check("x0_src_nostall", issue_stall, 0);
        cyc();
        issue_valid = 0;
        check("busy3_set", busy_vec, 32'h08);
        alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
        cyc();
        alu_valid = 0;

        // Reset mid-operation.
        issue_valid = 1; issue_rd = 5;
        cyc();
        issue_rd = 7;
        cyc();
        issue_valid = 0;
        check("busy_a0", busy_vec, 32'hA0);
        alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
        reset = 1;
        cyc();
        reset = 0;
        lsu_valid = 1; lsu_rd = 10; lsu_data = 32'h1010;
        #1;
        check("rst2_busy", busy_vec, 0);
        check("rst2_wb_en", wb_en, 0);
        check("rst2_alu_first", alu_ready, 1);
        check("rst2_lsu_wait", lsu_ready, 0);
        cyc();
        alu_valid = 0;
        check("rst2_wb_addr9", wb_addr, 9);
        check("rst2_wb_data9", wb_data, 32'h99);
        #1 check("rst2_lsu_ready", lsu_ready, 1);
        cyc();
        lsu_valid = 0;
        check("rst2_wb_addr10", wb_addr, 10);
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32-entry register file.
- Merges writeback requests from the ALU and the LSU with round-robin arbitration and drives the port's address, data and write-enable from registers.
- Keeps a busy scoreboard of destination registers that are issued but not yet written back, and raises a stall to the issue stage on RAW and WAW hazards.
- Sits between the execute/memory stages and the register file.

Parameters:
- XLEN, 32, data width of writeback data.
- NREG, 32, number of architectural registers; x0 is hardwired zero.
- AW, 5, register address width; must equal clog2(NREG).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- issue_valid  in  1  issue stage presents an instruction
- issue_rd  in  AW  destination register of the issuing instruction
- issue_rs1  in  AW  source register 1
- issue_rs2  in  AW  source register 2
- issue_stall  out  1  combinational; instruction must not issue this cycle
- alu_valid  in  1  ALU writeback request
- alu_rd  in  AW  ALU destination
- alu_data  in  XLEN  ALU result
- alu_ready  out  1  combinational; ALU request accepted this cycle
- lsu_valid  in  1  LSU writeback request
- lsu_rd  in  AW  LSU destination
- lsu_data  in  XLEN  load data
- lsu_ready  out  1  combinational; LSU request accepted this cycle
- wb_en  out  1  registered register-file write enable
- wb_addr  out  AW  registered register-file write address
- wb_data  out  XLEN  registered register-file write data
- busy_vec  out  NREG  registered scoreboard, bit i = register i pending

Behaviour:
- Reset (synchronous, active-high, clock clk):
  - wb_en=0, wb_addr=0, wb_data=0, busy_vec=0.
  - last_grant=LSU, so the ALU wins the first contention.
  - Reset asserted mid-operation drops in-flight grants and clears all busy bits. Requesters must re-present after reset.
- Arbitration, combinational in cycle T:
  - Only one of ALU/LSU valid: that one is granted.
  - Both valid: the one not equal to last_grant is granted.
  - Neither valid: no grant.
  - alu_ready = grant_alu, lsu_ready = grant_lsu; never both high.
  - A transfer occurs when valid and ready are both high. A requester holds valid/rd/data stable until ready.
  - last_grant updates only on a transfer.
- Writeback pipeline, 1-cycle latency:
  - A transfer in cycle T sets wb_en=1 in T+1, with wb_addr/wb_data taken from the granted requester.
  - No transfer in T: wb_en=0 in T+1; wb_addr/wb_data hold their previous values.
  - Transfer with rd=0: accepted, ready high, but wb_en stays 0 in T+1. x0 is never written.
- Scoreboard:
  - Issue accepted (issue_valid && !issue_stall) with issue_rd≠0: sets busy[issue_rd] at the end of the cycle.
  - Writeback transfer with rd≠0: clears busy[rd] at the end of the cycle T, so the bit is clear from T+1.
  - busy[0] is always 0.
  - issue_stall = issue_valid && (busy[rs1] | busy[rs2] | busy[rd]), using registered busy_vec. Read ports of x0 never stall.
  - Set and clear of the same register in the same cycle cannot occur without the optional feature (issue is stalled while busy). With the feature enabled, set wins.
  - Writeback to a non-busy register: write still performed; busy bit stays 0; no error.
- issue_stall is 0 whenever issue_valid=0.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: the busy bit of the register whose writeback transfers in cycle T is treated as clear for issue_stall in T.
  - Removes one stall cycle.
  - If that register is also issue_rd, the set wins and the bit remains 1.
- Undefined: issue_stall uses registered busy_vec only; a dependent instruction issues no earlier than T+1.

Test Plan:
- Reset → wb_en=0, busy_vec=0, issue_stall=0, alu_ready=lsu_ready=0 with no valids.
- Issue rd=5, then issue rs1=5 next cycle → issue_stall=1.
  - ALU writes rd=5 data 0xDEADBEEF at T → wb_en=1, wb_addr=5, wb_data=0xDEADBEEF at T+1.
  - busy_vec[5]=0 at T+1; stall drops at T+1 (at T with WB_BYPASS_EN).
- ALU and LSU valid for 4 consecutive cycles with rd 1..4 → grants ALU, LSU, ALU, LSU; wb_addr sequence follows with 1-cycle lag.
- LSU transfer with rd=0, data 0x12345678 → lsu_ready=1, wb_en=0 next cycle, busy_vec unchanged.
- Issue rd=7 while busy[7]=1 → issue_stall=1 (WAW).
  - Issue rs1=0, rs2=0, rd=3 with busy_vec=0 → no stall; busy_vec[3]=1 next cycle.
- Reset asserted while busy_vec=0x000000A0 and an ALU request is pending → busy_vec=0 and wb_en=0 next cycle; request re-granted after reset deasserts.
